// File: rtl/nand_target_if_if.sv
// Synchronous backing-memory port of the NAND target: byte address, write strobe,
// read strobe and read data that returns one cycle after the read strobe.
`timescale 1ns/1ps
interface nand_target_if_if;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re,
                  input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re,
                  output mem_rdata);
endinterface

// File: rtl/nand_target_if.sv
// Device-side NAND target: decodes CLE/ALE/WEN/REN strobes, holds one 512-byte
// page register and moves whole pages to/from a 256 KB backing memory.
`timescale 1ns/1ps
module nand_target_if #(
  parameter int PROG_BUSY = 16,
  parameter int READ_BUSY = 4
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [7:0]       F_IO,
  input  logic             F_CLE,
  input  logic             F_ALE,
  input  logic             F_WEN,
  input  logic             F_REN,
  output logic             F_RB,
  nand_target_if_if.master mem,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_RD_LOAD, ST_RD_WAIT, ST_RD_OUT, ST_PG_DATA, ST_PG_WRITE, ST_PG_BUSY
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  col_q, col_d;      // bit 9 marks "page full" during data input
  logic [8:0]  row_q, row_d;
  logic [1:0]  acnt_q, acnt_d;
  logic        rd_type_q, rd_type_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ld_vld_q, ld_vld_d;
  logic [8:0]  ld_idx_q, ld_idx_d;

  // [0],[1] synchroniser stages, [2] delayed copy for edge detection
  logic [2:0]  wen_sync_q, ren_sync_q;
  logic [1:0]  cle_sync_q, ale_sync_q;

  logic [7:0]  page_q [512];
  logic        pg_we;
  logic [8:0]  pg_waddr;
  logic [7:0]  pg_wdata;

  logic        rb, wen_rise, ren_rise, cmd_lat, adr_lat, dat_lat;
  logic [17:0] mem_addr_w;
  logic [7:0]  mem_wdata_w;
  logic        mem_we_w, mem_re_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_sync_q <= 3'b111;
      ren_sync_q <= 3'b111;
      cle_sync_q <= 2'b00;
      ale_sync_q <= 2'b00;
    end else begin
      wen_sync_q <= {wen_sync_q[1:0], F_WEN};
      ren_sync_q <= {ren_sync_q[1:0], F_REN};
      cle_sync_q <= {cle_sync_q[0], F_CLE};
      ale_sync_q <= {ale_sync_q[0], F_ALE};
    end
  end

  assign rb       = !(state_q inside {ST_RD_LOAD, ST_RD_WAIT, ST_PG_WRITE, ST_PG_BUSY});
  assign wen_rise = wen_sync_q[1] & ~wen_sync_q[2];
  assign ren_rise = ren_sync_q[1] & ~ren_sync_q[2];
  assign cmd_lat  = rb && wen_rise && cle_sync_q[1];
  assign adr_lat  = rb && wen_rise && !cle_sync_q[1] && ale_sync_q[1];
  assign dat_lat  = rb && wen_rise && !cle_sync_q[1] && !ale_sync_q[1];

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    acnt_d      = acnt_q;
    rd_type_d   = rd_type_q;
    cnt_d       = cnt_q;
    ld_vld_d    = 1'b0;
    ld_idx_d    = cnt_q[8:0];
    pg_we       = ld_vld_q;
    pg_waddr    = ld_idx_q;
    pg_wdata    = mem.mem_rdata;
    mem_addr_w  = '0;
    mem_wdata_w = '0;
    mem_we_w    = 1'b0;
    mem_re_w    = 1'b0;

    case (state_q)
      ST_RD_LOAD: begin
        if (cnt_q < 10'd512) begin
          mem_re_w   = 1'b1;
          mem_addr_w = {row_q, cnt_q[8:0]};
          ld_vld_d   = 1'b1;
          cnt_d      = cnt_q + 10'd1;
        end else begin
          state_d = ST_RD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 10'(READ_BUSY - 1)) begin
          state_d = ST_RD_OUT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 10'd1;
      end
      ST_RD_OUT: begin
        if (ren_rise && col_q[8:0] != 9'd511) col_d = col_q + 10'd1;
      end
      ST_PG_DATA: begin
        if (dat_lat && !col_q[9]) begin
          pg_we    = 1'b1;
          pg_waddr = col_q[8:0];
          pg_wdata = F_IO;
          col_d    = col_q + 10'd1;
        end
      end
      ST_PG_WRITE: begin
        mem_we_w    = 1'b1;
        mem_addr_w  = {row_q, cnt_q[8:0]};
        mem_wdata_w = page_q[cnt_q[8:0]];
        if (cnt_q == 10'd511) begin
          state_d = ST_PG_BUSY;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 10'd1;
      end
      ST_PG_BUSY: begin
        if (cnt_q == 10'(PROG_BUSY - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 10'd1;
      end
      default: ;
    endcase

    if (cmd_lat) begin
      acnt_d = '0;
      case (F_IO)
        8'h00, 8'h01, 8'h80: begin
          if (state_q inside {ST_IDLE, ST_RD_OUT, ST_PG_DATA}) begin
            state_d   = ST_ADDR;
            rd_type_d = (F_IO != 8'h80);
            col_d     = {1'b0, F_IO[0], col_q[7:0]};
          end
        end
        8'h10: begin
          if (state_q == ST_PG_DATA) begin
            state_d = ST_PG_WRITE;
            cnt_d   = '0;
          end
        end
        8'hFF:   state_d = ST_IDLE;
        default: ;
      endcase
    end else if (adr_lat && state_q == ST_ADDR) begin
      case (acnt_q)
        2'd0: begin
          col_d[7:0] = F_IO;
          acnt_d     = 2'd1;
        end
        2'd1: begin
          row_d[7:0] = F_IO;
          acnt_d     = 2'd2;
        end
        default: begin
          row_d[8] = F_IO[0];
          acnt_d   = '0;
          cnt_d    = '0;
          state_d  = rd_type_q ? ST_RD_LOAD : ST_PG_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      acnt_q    <= '0;
      rd_type_q <= 1'b0;
      cnt_q     <= '0;
      ld_vld_q  <= 1'b0;
      ld_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      acnt_q    <= acnt_d;
      rd_type_q <= rd_type_d;
      cnt_q     <= cnt_d;
      ld_vld_q  <= ld_vld_d;
      ld_idx_q  <= ld_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pg_we) page_q[pg_waddr] <= pg_wdata;
  end

  // Output enable follows the synchronised REN, not the pin
  assign F_IO          = (state_q == ST_RD_OUT && !ren_sync_q[1]) ? page_q[col_q[8:0]] : 8'bz;
  assign F_RB          = rb;
  assign mem.mem_addr  = mem_addr_w;
  assign mem.mem_wdata = mem_wdata_w;
  assign mem.mem_we    = mem_we_w;
  assign mem.mem_re    = mem_re_w;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nand_target_if.sv
// Bench for nand_target_if: drives the strobe protocol, models the backing memory
// and checks busy times, page contents and read streams against a page-level model.
`timescale 1ns/1ps
module tb_nand_target_if;
  localparam int PROG_BUSY = 16;
  localparam int READ_BUSY = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_cle = 1'b0, f_ale = 1'b0, f_wen = 1'b1, f_ren = 1'b1;
  logic       f_rb;
  logic [2:0] dbg_state;
  logic       io_en = 1'b0;
  logic [7:0] io_drv = 8'h00;
  wire  [7:0] f_io;

  assign f_io = io_en ? io_drv : 8'bz;

  nand_target_if_if mem_bus ();

  nand_target_if #(.PROG_BUSY(PROG_BUSY), .READ_BUSY(READ_BUSY)) dut (
    .clk(clk), .rst(rst), .F_IO(f_io), .F_CLE(f_cle), .F_ALE(f_ale),
    .F_WEN(f_wen), .F_REN(f_ren), .F_RB(f_rb), .mem(mem_bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- backing memory ----------------
  int unsigned seed = 32'h1234_5678;
  logic [7:0]  mem [262144];
  bit          written [262144];
  logic [7:0]  rdata_q = 8'h00;
  int          wr_count = 0;

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ seed;
    return h[18:11];
  endfunction

  function automatic logic [7:0] mem_rd(input int a);
    return written[a] ? mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_bus.mem_we) begin
      mem[mem_bus.mem_addr]     <= mem_bus.mem_wdata;
      written[mem_bus.mem_addr] <= 1'b1;
      wr_count                  <= wr_count + 1;
    end
    if (mem_bus.mem_re) rdata_q <= mem_rd(int'(mem_bus.mem_addr));
  end
  assign mem_bus.mem_rdata = rdata_q;

  // ---------------- busy monitor ----------------
  int busy_run = 0, busy_last = 0, busy_seen = 0;
  always @(negedge clk) begin
    if (rst) busy_run <= 0;
    else if (!f_rb) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      busy_last <= busy_run;
      busy_seen <= busy_seen + 1;
      busy_run  <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_mem [262144];
  logic [7:0] m_page [512];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wen_cycle(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge clk);
    io_drv = d; io_en = 1'b1; f_cle = cle; f_ale = ale; f_wen = 1'b0;
    repeat (3) @(negedge clk);
    f_wen = 1'b1;
    repeat (4) @(negedge clk);
    f_cle = 1'b0; f_ale = 1'b0; io_en = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);  wen_cycle(1'b1, 1'b0, d); endtask
  task automatic adr(input logic [7:0] d);  wen_cycle(1'b0, 1'b1, d); endtask
  task automatic dat(input logic [7:0] d);  wen_cycle(1'b0, 1'b0, d); endtask

  task automatic ren_cycle(output logic [7:0] d);
    @(negedge clk);
    f_ren = 1'b0;
    repeat (3) @(negedge clk);
    d = f_io;
    f_ren = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_addr(input logic [7:0] col0, input int row);
    logic [8:0] r;
    r = 9'(row);
    adr(col0);
    adr(r[7:0]);
    adr({7'b0, r[8]});
  endtask

  task automatic wait_ready(input string tag, input int exp_len, input int start);
    int n;
    n = 0;
    while (busy_seen == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(n < 3000), 32'd1);
    check({tag, "_busy_len"}, busy_last, exp_len);
  endtask

  task automatic do_program(input int row, input int n_bytes, input bit pattern, input bit inject);
    int c, start, errs;
    logic [7:0] d;
    cmd(8'h80);
    send_addr(8'h00, row);
    c = 0;
    for (int i = 0; i < n_bytes; i++) begin
      d = pattern ? 8'(i ^ 8'h5A) : 8'($urandom_range(0, 255));
      dat(d);
      if (c < 512) m_page[c] = d;
      c++;
    end
    cmd(8'h10);
    start = busy_seen;
    check("pg_rb_low", f_rb, 1'b0);
    if (inject) begin
      cmd(8'hFF);
      cmd(8'h10);
    end
    wait_ready("pg", 512 + PROG_BUSY, start);
    for (int i = 0; i < 512; i++) exp_mem[row * 512 + i] = m_page[i];
    errs = 0;
    for (int i = 0; i < 512; i++) if (mem_rd(row * 512 + i) !== exp_mem[row * 512 + i]) errs++;
    check("pg_mem", errs, 0);
  endtask

  task automatic do_read(input logic [7:0] cmd_b, input int row, input logic [7:0] col0,
                         input int n_ren, input int unk_at, input bit inject,
                         output logic [7:0] first, output logic [7:0] last);
    int c, start, errs;
    logic [7:0] d;
    cmd(cmd_b);
    send_addr(col0, row);
    start = busy_seen;
    check("rd_rb_low", f_rb, 1'b0);
    if (inject) cmd(8'hFF);
    wait_ready("rd", 513 + READ_BUSY, start);
    for (int i = 0; i < 512; i++) m_page[i] = exp_mem[row * 512 + i];
    c = (cmd_b[0] ? 256 : 0) + int'(col0);
    errs = 0;
    first = 8'h00;
    last = 8'h00;
    for (int k = 0; k < n_ren; k++) begin
      if (k == unk_at) begin
        cmd(8'h3C);
        check("unk_cmd_rb", f_rb, 1'b1);
      end
      ren_cycle(d);
      if (k == 0) first = d;
      last = d;
      if (d !== m_page[c]) errs++;
      if (c < 511) c++;
    end
    check("rd_stream", errs, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] first, last;
    int row, start_wr, n, errs;

    seed = $urandom;
    for (int i = 0; i < 262144; i++) exp_mem[i] = init_byte(i);

    repeat (3) @(negedge clk);
    check("rst_rb", f_rb, 1'b1);
    check("rst_we", mem_bus.mem_we, 1'b0);
    check("rst_re", mem_bus.mem_re, 1'b0);
    check("rst_addr", mem_bus.mem_addr, 18'h0);
    check("rst_wdata", mem_bus.mem_wdata, 8'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // program row 261 with i^0x5A, then read it back with an unknown command mid-stream
    do_program(261, 512, 1'b1, 1'b0);
    errs = 0;
    for (int i = 0; i < 512; i++) if (mem_rd(32'h20A00 + i) !== 8'(i ^ 8'h5A)) errs++;
    check("pg261_pattern", errs, 0);
    do_read(8'h00, 261, 8'h00, 512, 100, 1'b0, first, last);
    check("rd261_first", first, 8'h5A);
    check("rd261_last", last, 8'(511 ^ 8'h5A));

    // 0x01 with col 0x10: starts at byte 0x110, saturates at 511
    row = $urandom_range(0, 511);
    do_read(8'h01, row, 8'h10, 301, -1, 1'b0, first, last);
    check("rd01_first", first, exp_mem[row * 512 + 32'h110]);
    check("rd01_sat", last, exp_mem[row * 512 + 511]);

    // overlong data phase: only the first 512 bytes land
    row = $urandom_range(0, 511);
    do_program(row, 600, 1'b0, 1'b0);

    // 0xFF / 0x10 during busy are ignored
    row = $urandom_range(0, 511);
    do_program(row, 512, 1'b0, 1'b1);
    do_read(8'h00, row, 8'h00, 64, -1, 1'b1, first, last);

    // reset in the middle of the page write
    row = $urandom_range(0, 511);
    cmd(8'h80);
    send_addr(8'h00, row);
    for (int i = 0; i < 512; i++) begin
      m_page[i] = 8'($urandom_range(0, 255));
      dat(m_page[i]);
    end
    start_wr = wr_count;
    cmd(8'h10);
    n = 0;
    while (wr_count - start_wr < 200 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach", wr_count - start_wr, 200);
    rst = 1'b1;
    #1;
    check("rst_mid_rb", f_rb, 1'b1);
    check("rst_mid_we", mem_bus.mem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 200; i++) exp_mem[row * 512 + i] = m_page[i];
    errs = 0;
    for (int i = 0; i < 512; i++) if (mem_rd(row * 512 + i) !== exp_mem[row * 512 + i]) errs++;
    check("rst_mid_mem", errs, 0);
    do_read(8'h00, row, 8'hC0, 80, -1, 1'b0, first, last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
